swc_delay_ctl: RTL and testbench
================================

Name: swc_delay_ctl

Overview:
Sequencer that drives one software-controlled 24-bit counter (Swc) as a programmable delay timer. It accepts a 24-bit delay request, issues the LD0/LD1/LD2 load sequence over the Swc 12-bit instruction port, and starts a continuous count-down (CCD). When the Swc reports zero, it pulses done. Requests can be aborted; an abort stops the count with CCS.

Parameters:
INIT_CYCLES, 2, cycles held in INIT after reset release before the first request is accepted (covers the Swc reset-to-ready cycle); legal range 1..15.

Ports:
clock  in  1  system clock; all state changes on posedge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request strobe.
req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
req_delay  in  24  delay in cycles, unsigned; sampled on accept.
abort  in  1  cancel the active request; level-sampled each cycle.
busy  out  1  high in every state except INIT and IDLE.
done  out  1  one-cycle pulse on normal completion.
aborted  out  1  one-cycle pulse on abort completion.
done_count  out  8  completed-request count (done pulses only); wraps 255->0.
swc_inst  out  12  Swc instruction: [11:8] opcode, [7:0] immediate.
swc_inst_en  out  1  Swc instruction valid.
swc_ready  in  1  Swc zero flag, combinational from the Swc next-counter value.

Behaviour:
- Opcodes: NOP=0, LD0=1, LD1=2, LD2=3, CCD=7, CCS=8. No other opcode is ever driven.
- Outputs are registered except req_ready and busy, which decode directly from state.
- Reset values: state=INIT, req_ready=0, busy=0, done=0, aborted=0, done_count=0, swc_inst=12'h000, swc_inst_en=0, delay register=0, init counter=0.
- Reset mid-operation: return to INIT immediately and drop all pending work. No CCS is issued; the Swc is reset from the same line.
- swc_inst_en=0 implies swc_inst=12'h000.
- States and transitions:
  - INIT: counts INIT_CYCLES cycles, then goes to IDLE. abort and req_valid are ignored.
  - IDLE: on accept, capture req_delay into D and go to LD0. abort is ignored.
  - LD0: drive {LD0, D[7:0]} with en=1, then go to LD1.
  - LD1: drive {LD1, D[15:8]}, then go to LD2.
  - LD2: drive {LD2, D[23:16]}. If D==0, go to DONE; otherwise go to START.
  - START: drive {CCD, 8'h00}, then go to RUN. If swc_ready=1 in this cycle (D==1), go to DONE instead.
  - RUN: en=0. Go to DONE when swc_ready=1.
  - DONE: en=0. Assert done for 1 cycle, increment done_count, then go to IDLE.
  - ABORT: drive {CCS, 8'h00} for 1 cycle, assert aborted, then go to IDLE.
- Abort: if abort=1 in LD0, LD1, LD2, START or RUN, the next state is ABORT. The instruction for the current state is still driven that cycle.
- Simultaneous events:
  - abort with swc_ready=1 in START or RUN: completion wins; go to DONE, no aborted pulse.
  - abort while D==0 in LD2: go to DONE.
- Latency (accept at cycle 0):
  - LD0/LD1/LD2 at cycles 1-3; CCD at cycle 4.
  - Swc counter reaches 0 at cycle D+3; done is high at cycle D+4 for D>=1, and at cycle 4 for D=0.
  - req_ready returns at cycle D+5 (cycle 5 for D=0).
- swc_ready is only evaluated in START and RUN; it is ignored in all other states.
- Back-to-back: a request presented in the first IDLE cycle after DONE is accepted without a gap.

Test Plan:
- Reset, INIT_CYCLES=2 -> req_ready=0 for 2 cycles after reset falls, then 1; all outputs at reset values meanwhile.
- Accept D=24'h123456 -> swc_inst 12'h156, 12'h234, 12'h312, 12'h700 on cycles 1-4. Swc counter hits 0 at cycle 0x123459; done at 0x12345A; done_count=1.
- D=0 -> LD0/LD1/LD2 with imm 0, no CCD; done at cycle 4. D=1 -> CCD at cycle 4, done at cycle 5.
- D=100, abort at cycle 20 -> swc_inst=12'h800 at cycle 21 with aborted=1; Swc counter frozen at 83; req_ready=1 at cycle 22; done_count unchanged.
- D=5, abort in the cycle swc_ready rises (cycle 8) -> done at cycle 9, no CCS, aborted stays 0.
- 256 back-to-back D=1 requests -> done_count wraps to 0. Reset asserted in RUN -> next cycle state INIT, busy=0, no done pulse.

Source files
------------

// File: rtl/swc_delay_ctl_if.sv
// Request handshake, status and Swc instruction bus of the delay sequencer.
// master is the sequencer side, slave is the requester/Swc side.
interface swc_delay_ctl_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_delay;
  logic        abort;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [7:0]  done_count;
  logic [11:0] swc_inst;
  logic        swc_inst_en;
  logic        swc_ready;

  modport master (
    input  req_valid, req_delay, abort, swc_ready,
    output req_ready, busy, done, aborted, done_count, swc_inst, swc_inst_en
  );

  modport slave (
    output req_valid, req_delay, abort, swc_ready,
    input  req_ready, busy, done, aborted, done_count, swc_inst, swc_inst_en
  );
endinterface

// File: rtl/swc_delay_ctl.sv
// Delay-timer sequencer for one Swc: loads a 24-bit count with LD0/LD1/LD2,
// runs it down with CCD, reports completion, and stops it with CCS on abort.
module swc_delay_ctl #(
  parameter int unsigned INIT_CYCLES = 2
) (
  input logic             clock,
  input logic             reset,
  swc_delay_ctl_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT  = 4'd0,
    S_IDLE  = 4'd1,
    S_LD0   = 4'd2,
    S_LD1   = 4'd3,
    S_LD2   = 4'd4,
    S_START = 4'd5,
    S_RUN   = 4'd6,
    S_DONE  = 4'd7,
    S_ABORT = 4'd8
  } state_t;

  localparam logic [3:0] OP_LD0 = 4'h1;
  localparam logic [3:0] OP_LD1 = 4'h2;
  localparam logic [3:0] OP_LD2 = 4'h3;
  localparam logic [3:0] OP_CCD = 4'h7;
  localparam logic [3:0] OP_CCS = 4'h8;

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  init_cnt;
  logic [23:0] delay;
  logic        done_r;
  logic        aborted_r;
  logic [7:0]  done_count_r;
  logic [11:0] inst_r;
  logic        inst_en_r;

  function automatic logic [11:0] swc_word(input logic [3:0] op, input logic [7:0] imm);
    return {op, imm};
  endfunction

  assign bus.req_ready   = (state == S_IDLE);
  assign bus.busy        = (state != S_INIT) && (state != S_IDLE);
  assign bus.done        = done_r;
  assign bus.aborted     = aborted_r;
  assign bus.done_count  = done_count_r;
  assign bus.swc_inst    = inst_r;
  assign bus.swc_inst_en = inst_en_r;

  // Registered outputs are loaded together with the state they belong to, so
  // the instruction for a state is on the bus for exactly the cycle spent there.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_INIT;
      init_cnt     <= 4'd0;
      delay        <= 24'd0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
      done_count_r <= 8'd0;
      inst_r       <= 12'h000;
      inst_en_r    <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      inst_r    <= 12'h000;
      inst_en_r <= 1'b0;
      case (state)
        S_INIT: begin
          if (init_cnt == INIT_LAST) begin
            state <= S_IDLE;
          end else begin
            init_cnt <= init_cnt + 4'd1;
          end
        end
        S_IDLE: begin
          if (bus.req_valid) begin
            delay     <= bus.req_delay;
            state     <= S_LD0;
            inst_r    <= swc_word(OP_LD0, bus.req_delay[7:0]);
            inst_en_r <= 1'b1;
          end
        end
        S_LD0: begin
          inst_en_r <= 1'b1;
          if (bus.abort) begin
            state     <= S_ABORT;
            aborted_r <= 1'b1;
            inst_r    <= swc_word(OP_CCS, 8'h00);
          end else begin
            state  <= S_LD1;
            inst_r <= swc_word(OP_LD1, delay[15:8]);
          end
        end
        S_LD1: begin
          inst_en_r <= 1'b1;
          if (bus.abort) begin
            state     <= S_ABORT;
            aborted_r <= 1'b1;
            inst_r    <= swc_word(OP_CCS, 8'h00);
          end else begin
            state  <= S_LD2;
            inst_r <= swc_word(OP_LD2, delay[23:16]);
          end
        end
        S_LD2: begin
          // A zero delay is complete once loaded; it beats a concurrent abort.
          if (delay == 24'd0) begin
            state        <= S_DONE;
            done_r       <= 1'b1;
            done_count_r <= done_count_r + 8'd1;
          end else if (bus.abort) begin
            state     <= S_ABORT;
            aborted_r <= 1'b1;
            inst_r    <= swc_word(OP_CCS, 8'h00);
            inst_en_r <= 1'b1;
          end else begin
            state     <= S_START;
            inst_r    <= swc_word(OP_CCD, 8'h00);
            inst_en_r <= 1'b1;
          end
        end
        S_START, S_RUN: begin
          // Zero reached in the same cycle as an abort counts as completion.
          if (bus.swc_ready) begin
            state        <= S_DONE;
            done_r       <= 1'b1;
            done_count_r <= done_count_r + 8'd1;
          end else if (bus.abort) begin
            state     <= S_ABORT;
            aborted_r <= 1'b1;
            inst_r    <= swc_word(OP_CCS, 8'h00);
            inst_en_r <= 1'b1;
          end else begin
            state <= S_RUN;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_ABORT: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swc_delay_ctl.sv
// Bench for swc_delay_ctl with a small behavioural Swc counter on the bus.
module tb_swc_delay_ctl;

  logic clock;
  logic reset;

  swc_delay_ctl_if bus();

  swc_delay_ctl #(.INIT_CYCLES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Swc stand-in: 24-bit counter, byte loads, continuous count-down and stop.
  logic [23:0] sw_cnt;
  logic [23:0] sw_next;
  logic        sw_run;
  logic        sw_run_next;
  logic        sw_active;
  logic [3:0]  sw_op;
  logic [7:0]  sw_imm;

  assign sw_op  = bus.swc_inst[11:8];
  assign sw_imm = bus.swc_inst[7:0];

  always_comb begin
    sw_next     = sw_cnt;
    sw_run_next = sw_run;
    sw_active   = 1'b0;
    if (bus.swc_inst_en) begin
      case (sw_op)
        4'h1: begin sw_next[7:0]   = sw_imm; sw_run_next = 1'b0; end
        4'h2: begin sw_next[15:8]  = sw_imm; sw_run_next = 1'b0; end
        4'h3: begin sw_next[23:16] = sw_imm; sw_run_next = 1'b0; end
        4'h7: begin sw_next = sw_cnt - 24'd1; sw_run_next = 1'b1; sw_active = 1'b1; end
        4'h8: begin sw_run_next = 1'b0; end
        default: begin
          if (sw_run) begin
            sw_next   = sw_cnt - 24'd1;
            sw_active = 1'b1;
          end
        end
      endcase
    end else if (sw_run) begin
      sw_next   = sw_cnt - 24'd1;
      sw_active = 1'b1;
    end
  end

  assign bus.swc_ready = sw_active && (sw_next == 24'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      sw_cnt <= 24'd0;
      sw_run <= 1'b0;
    end else begin
      sw_cnt <= sw_next;
      sw_run <= sw_run_next;
    end
  end

  typedef struct {
    logic [23:0] delay;
    int          abort_cyc;
    logic [11:0] i1;
    logic [11:0] i2;
    logic [11:0] i3;
    logic [11:0] i4;
    int          exp_end;
    bit          exp_done;
    int          exp_ccd;
    int          exp_ccs;
    bit          chk_frozen;
    logic [23:0] frozen;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic [23:0] d, input int ab,
                              input logic [11:0] i1, input logic [11:0] i2,
                              input logic [11:0] i3, input logic [11:0] i4,
                              input int e, input bit dn, input int ccd, input int ccs,
                              input bit cf, input logic [23:0] fz);
    vec_t v;
    v.delay = d; v.abort_cyc = ab;
    v.i1 = i1; v.i2 = i2; v.i3 = i3; v.i4 = i4;
    v.exp_end = e; v.exp_done = dn; v.exp_ccd = ccd; v.exp_ccs = ccs;
    v.chk_frozen = cf; v.frozen = fz;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bus.req_ready && n < 300) begin
      tick();
      n++;
    end
    check(name, int'(bus.req_ready), 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          done_cyc, ab_cyc, rdy_cyc, ccd, ccs, bad_idle, bound;
    logic [11:0] inst [1:4];
    logic [7:0]  dc0;
    logic [23:0] cnt_at_rdy;
    wait_ready($sformatf("v%0d_ready_in", idx));
    dc0 = bus.done_count;
    done_cyc = -1; ab_cyc = -1; rdy_cyc = -1;
    ccd = 0; ccs = 0; bad_idle = 0; cnt_at_rdy = 24'd0;
    for (int k = 1; k <= 4; k++) inst[k] = 12'hFFF;
    bound = ((v.delay > 24'd1000) ? 1000 : int'(v.delay)) + 40;
    bus.req_valid = 1'b1;
    bus.req_delay = v.delay;
    bus.abort     = 1'b0;
    for (int c = 1; c <= bound; c++) begin
      tick();
      bus.req_valid = 1'b0;
      bus.abort     = (c == v.abort_cyc);
      if (c <= 4) inst[c] = bus.swc_inst;
      if (bus.swc_inst_en && bus.swc_inst[11:8] == 4'h7) ccd++;
      if (bus.swc_inst_en && bus.swc_inst[11:8] == 4'h8) ccs++;
      if (!bus.swc_inst_en && bus.swc_inst != 12'h000) bad_idle++;
      if (bus.done && done_cyc < 0) done_cyc = c;
      if (bus.aborted && ab_cyc < 0) ab_cyc = c;
      if (bus.req_ready && rdy_cyc < 0) begin
        rdy_cyc    = c;
        cnt_at_rdy = sw_cnt;
      end
      if (rdy_cyc >= 0 && c >= 4) break;
    end
    bus.abort = 1'b0;
    check($sformatf("v%0d_inst1", idx), int'(inst[1]), int'(v.i1));
    check($sformatf("v%0d_inst2", idx), int'(inst[2]), int'(v.i2));
    check($sformatf("v%0d_inst3", idx), int'(inst[3]), int'(v.i3));
    check($sformatf("v%0d_inst4", idx), int'(inst[4]), int'(v.i4));
    if (v.exp_done) begin
      check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_end);
      check($sformatf("v%0d_no_aborted", idx), ab_cyc, -1);
    end else begin
      check($sformatf("v%0d_aborted_cycle", idx), ab_cyc, v.exp_end);
      check($sformatf("v%0d_no_done", idx), done_cyc, -1);
    end
    check($sformatf("v%0d_ready_cycle", idx), rdy_cyc, v.exp_end + 1);
    check($sformatf("v%0d_ccd_count", idx), ccd, v.exp_ccd);
    check($sformatf("v%0d_ccs_count", idx), ccs, v.exp_ccs);
    check($sformatf("v%0d_en_low_inst_zero", idx), bad_idle, 0);
    check($sformatf("v%0d_done_count", idx), int'(bus.done_count),
          (int'(dc0) + int'(v.exp_done)) % 256);
    if (v.chk_frozen)
      check($sformatf("v%0d_swc_frozen", idx), int'(cnt_at_rdy), int'(v.frozen));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, last, dones;

    vecs[0]  = mk(24'd0,       -1, 12'h100, 12'h200, 12'h300, 12'h000,   4, 1'b1, 0, 0, 1'b0, 24'd0);
    vecs[1]  = mk(24'd1,       -1, 12'h101, 12'h200, 12'h300, 12'h700,   5, 1'b1, 1, 0, 1'b0, 24'd0);
    vecs[2]  = mk(24'd7,       -1, 12'h107, 12'h200, 12'h300, 12'h700,  11, 1'b1, 1, 0, 1'b0, 24'd0);
    vecs[3]  = mk(24'h000103,  -1, 12'h103, 12'h201, 12'h300, 12'h700, 263, 1'b1, 1, 0, 1'b0, 24'd0);
    vecs[4]  = mk(24'd100,     20, 12'h164, 12'h200, 12'h300, 12'h700,  21, 1'b0, 1, 1, 1'b1, 24'd83);
    vecs[5]  = mk(24'd5,        8, 12'h105, 12'h200, 12'h300, 12'h700,   9, 1'b1, 1, 0, 1'b0, 24'd0);
    vecs[6]  = mk(24'd3,        2, 12'h103, 12'h200, 12'h800, 12'h000,   3, 1'b0, 0, 1, 1'b0, 24'd0);
    vecs[7]  = mk(24'd0,        3, 12'h100, 12'h200, 12'h300, 12'h000,   4, 1'b1, 0, 0, 1'b0, 24'd0);
    vecs[8]  = mk(24'd10,       4, 12'h10A, 12'h200, 12'h300, 12'h700,   5, 1'b0, 1, 1, 1'b1, 24'd9);
    vecs[9]  = mk(24'h123456,  10, 12'h156, 12'h234, 12'h312, 12'h700,  11, 1'b0, 1, 1, 1'b1, 24'h12344F);
    vecs[10] = mk(24'd2,        1, 12'h102, 12'h800, 12'h000, 12'h000,   2, 1'b0, 0, 1, 1'b0, 24'd0);

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_delay = 24'd0;
    bus.abort     = 1'b0;
    repeat (3) tick();
    check("rst_req_ready", int'(bus.req_ready), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_aborted", int'(bus.aborted), 0);
    check("rst_done_count", int'(bus.done_count), 0);
    check("rst_swc_inst", int'(bus.swc_inst), 0);
    check("rst_swc_inst_en", int'(bus.swc_inst_en), 0);

    // Release reset; abort held high through INIT must have no effect.
    reset     = 1'b0;
    bus.abort = 1'b1;
    check("init_c0_req_ready", int'(bus.req_ready), 0);
    tick();
    check("init_c1_req_ready", int'(bus.req_ready), 0);
    check("init_c1_busy", int'(bus.busy), 0);
    tick();
    check("init_c2_req_ready", int'(bus.req_ready), 1);
    check("init_c2_busy", int'(bus.busy), 0);
    check("init_c2_aborted", int'(bus.aborted), 0);
    check("init_c2_inst_en", int'(bus.swc_inst_en), 0);

    // abort in IDLE is ignored.
    tick();
    check("idle_abort_busy", int'(bus.busy), 0);
    check("idle_abort_aborted", int'(bus.aborted), 0);
    check("idle_abort_ready", int'(bus.req_ready), 1);
    bus.abort = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Reset while the count is running.
    wait_ready("rstrun_ready_in");
    bus.req_valid = 1'b1;
    bus.req_delay = 24'd50;
    for (int c = 1; c <= 10; c++) begin
      tick();
      bus.req_valid = 1'b0;
    end
    check("rstrun_busy_before", int'(bus.busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstrun_busy", int'(bus.busy), 0);
    check("rstrun_req_ready_c0", int'(bus.req_ready), 0);
    check("rstrun_done", int'(bus.done), 0);
    check("rstrun_inst_en", int'(bus.swc_inst_en), 0);
    check("rstrun_inst", int'(bus.swc_inst), 0);
    check("rstrun_done_count", int'(bus.done_count), 0);
    tick();
    check("rstrun_req_ready_c1", int'(bus.req_ready), 0);
    tick();
    check("rstrun_req_ready_c2", int'(bus.req_ready), 1);
    dones = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (bus.done || bus.aborted) dones++;
    end
    check("rstrun_no_completion", dones, 0);

    // 256 back-to-back D=1 requests: one accept every 6 cycles, count wraps.
    wait_ready("b2b_ready_in");
    bus.req_valid = 1'b1;
    bus.req_delay = 24'd1;
    ndone = 0;
    last  = -1;
    for (int c = 1; c <= 2000 && ndone < 256; c++) begin
      tick();
      if (bus.done) begin
        ndone++;
        last = c;
        if (ndone == 128) check("b2b_count_mid", int'(bus.done_count), 128);
        if (ndone == 256) bus.req_valid = 1'b0;
      end
    end
    check("b2b_done_pulses", ndone, 256);
    check("b2b_last_done_cycle", last, 1535);
    repeat (3) tick();
    check("b2b_done_count_wrap", int'(bus.done_count), 0);
    check("b2b_idle_after", int'(bus.req_ready), 1);
    check("b2b_busy_after", int'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
